// File: rtl/dct_pkg.sv
// Shared FSM encoding and block geometry for the 1-D DCT sequencing controller.
package dct_pkg;
    localparam int BLK_LEN = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        COMP     = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } dct_state_e;
endpackage

// File: rtl/dct_addr_cnt.sv
// 3-bit sample/coefficient address counter with synchronous clear and a
// wrap flag that marks the enabled step from the last address back to 0.
module dct_addr_cnt
    import dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             wrap
);
    assign wrap = en && (cnt == IDX_W'(BLK_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dct_seq_ctrl.sv
// Sequences one 8-sample block into the DCT datapath, waits out its compute
// latency, then streams the 8 coefficients downstream over valid/ready.
module dct_seq_ctrl
    import dct_pkg::*;
#(
    parameter int N           = 8,
    parameter int COMP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      blk_cnt,
    output logic             dct_wr,
    output logic             dct_oe,
    output logic [IDX_W-1:0] dct_add,
    output logic [N-1:0]     dct_data_in,
    input  logic [N-1:0]     dct_data_out
);
    dct_state_e       state, state_nxt;
    logic [3:0]       comp_cnt;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_fire, rd_fire, wr_wrap, rd_wrap;

    // Abort suppresses both handshakes so neither side believes a transfer happened.
    assign wr_fire = (state == LOAD) && in_valid && !abort;
    assign rd_fire = (state == RD_WAIT) && out_valid && out_ready && !abort;

    dct_addr_cnt u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .en    (wr_fire),
        .cnt   (wr_idx),
        .wrap  (wr_wrap)
    );

    dct_addr_cnt u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .en    (rd_fire),
        .cnt   (rd_idx),
        .wrap  (rd_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        dct_wr      = 1'b0;
        dct_oe      = 1'b0;
        dct_add     = '0;
        dct_data_in = '0;
        case (state)
            LOAD: begin
                in_ready = !abort;
                if (wr_fire) begin
                    dct_wr      = 1'b1;
                    dct_add     = wr_idx;
                    dct_data_in = in_data;
                end
                if (wr_wrap)
                    state_nxt = COMP;
            end
            COMP: begin
                if (comp_cnt == 4'd0)
                    state_nxt = RD_ISSUE;
            end
            RD_ISSUE: begin
                dct_oe    = 1'b1;
                dct_add   = rd_idx;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_fire)
                    state_nxt = rd_wrap ? LOAD : RD_ISSUE;
            end
            default: state_nxt = LOAD;
        endcase
        if (abort)
            state_nxt = LOAD;
    end

    // Loaded as the final sample is accepted so COMP lasts exactly COMP_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            comp_cnt <= 4'd0;
        else if (abort)
            comp_cnt <= 4'd0;
        else if (wr_wrap)
            comp_cnt <= 4'(COMP_CYCLES - 1);
        else if (state == COMP && comp_cnt != 4'd0)
            comp_cnt <= comp_cnt - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            blk_cnt   <= 16'd0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else begin
            if (state == RD_ISSUE) begin
                out_valid <= 1'b1;
                out_data  <= dct_data_out;
                out_idx   <= rd_idx;
            end else if (rd_fire) begin
                out_valid <= 1'b0;
            end
            if (rd_fire && rd_wrap)
                blk_cnt <= blk_cnt + 16'd1;
        end
    end

    assign out_last = out_valid && (out_idx == IDX_W'(BLK_LEN - 1));
    assign busy     = !(state == LOAD && wr_idx == '0);
endmodule

// File: tb/tb_dct_seq_ctrl.sv
// Directed bench for dct_seq_ctrl with a datapath model returning 8'hA0+addr.
module tb_dct_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset, abort, in_valid, out_ready;
    logic       in_ready, out_valid, out_last, busy, dct_wr, dct_oe;
    logic [7:0] in_data, out_data, dct_data_in, dct_data_out;
    logic [2:0] out_idx, dct_add;
    logic [15:0] blk_cnt;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dct_data_out = dct_oe ? (8'hA0 + {5'd0, dct_add}) : 8'h00;

    dct_seq_ctrl #(.N(8), .COMP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .blk_cnt(blk_cnt),
        .dct_wr(dct_wr), .dct_oe(dct_oe), .dct_add(dct_add),
        .dct_data_in(dct_data_in), .dct_data_out(dct_data_out)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_block(input int base, input int step);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(base + step * i);
            #1;
            chk("wr_ready", {15'd0, in_ready}, 16'd1);
            chk("wr_strobe", {15'd0, dct_wr}, 16'd1);
            chk("wr_oe", {15'd0, dct_oe}, 16'd0);
            chk("wr_add", {13'd0, dct_add}, 16'(i));
            chk("wr_data", {8'd0, dct_data_in}, 16'(base + step * i));
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Exactly two COMP cycles; a sample offered here must not be written.
    task automatic comp_wait;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            #1;
            chk("comp_ready", {15'd0, in_ready}, 16'd0);
            chk("comp_wr", {15'd0, dct_wr}, 16'd0);
            chk("comp_oe", {15'd0, dct_oe}, 16'd0);
            chk("comp_busy", {15'd0, busy}, 16'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Reads idx 0..7; stalls 5 cycles at stall_idx; returns in RD_WAIT of cut_idx.
    task automatic read_block(input int stall_idx, input int cut_idx);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rd_oe", {15'd0, dct_oe}, 16'd1);
            chk("rd_add", {13'd0, dct_add}, 16'(i));
            chk("rd_wr", {15'd0, dct_wr}, 16'd0);
            tick();
            if (i == cut_idx) return;
            if (i == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    chk("stall_valid", {15'd0, out_valid}, 16'd1);
                    chk("stall_data", {8'd0, out_data}, 16'(8'hA0 + i));
                    chk("stall_oe", {15'd0, dct_oe}, 16'd0);
                    tick();
                end
                out_ready = 1'b1;
            end
            #1;
            chk("out_valid", {15'd0, out_valid}, 16'd1);
            chk("out_data", {8'd0, out_data}, 16'(8'hA0 + i));
            chk("out_idx", {13'd0, out_idx}, 16'(i));
            chk("out_last", {15'd0, out_last}, {15'd0, i == 7});
            chk("wait_oe", {15'd0, dct_oe}, 16'd0);
            tick();
        end
        #1;
        chk("end_valid", {15'd0, out_valid}, 16'd0);
        chk("end_ready", {15'd0, in_ready}, 16'd1);
        chk("end_busy", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        reset = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        #2;
        chk("rst_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_blk", blk_cnt, 16'd0);
        chk("rst_wr", {15'd0, dct_wr}, 16'd0);
        chk("rst_oe", {15'd0, dct_oe}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        tick();
        reset = 1'b0;
        tick();

        // Block 1: 10..80, free-running reads
        write_block(10, 10);
        comp_wait();
        read_block(99, 99);
        chk("blk1_cnt", blk_cnt, 16'd1);

        // Block 2: stall downstream on idx 3
        write_block(1, 3);
        comp_wait();
        read_block(3, 99);
        chk("blk2_cnt", blk_cnt, 16'd2);

        // Abort after 5 writes; the coincident sample is dropped
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(i); tick();
        end
        in_data = 8'h99; abort = 1'b1;
        #1;
        chk("abort_wr", {15'd0, dct_wr}, 16'd0);
        tick();
        abort = 1'b0;
        #1;
        chk("post_abort_ready", {15'd0, in_ready}, 16'd1);
        chk("post_abort_wr", {15'd0, dct_wr}, 16'd1);
        chk("post_abort_add", {13'd0, dct_add}, 16'd0);
        chk("post_abort_data", {8'd0, dct_data_in}, 16'h99);
        chk("post_abort_blk", blk_cnt, 16'd2);
        in_valid = 1'b0;
        #1;
        chk("post_abort_busy", {15'd0, busy}, 16'd0);
        tick();
        write_block(7, 1);
        comp_wait();
        read_block(99, 99);
        chk("blk3_cnt", blk_cnt, 16'd3);

        // Reset while holding coefficient 4
        write_block(2, 2);
        comp_wait();
        read_block(99, 4);
        out_ready = 1'b0;
        #1;
        chk("pre_rst_valid", {15'd0, out_valid}, 16'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_data", {8'd0, out_data}, 16'd0);
        chk("mid_rst_idx", {13'd0, out_idx}, 16'd0);
        chk("mid_rst_blk", blk_cnt, 16'd0);
        chk("mid_rst_ready", {15'd0, in_ready}, 16'd1);
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        chk("mid_rst_oe", {15'd0, dct_oe}, 16'd0);
        tick();
        reset = 1'b0;
        tick();
        write_block(20, 5);
        comp_wait();
        read_block(99, 99);
        chk("blk_after_rst", blk_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
